ccd_capture_roi: RTL and testbench

- Parametrised successor to the team's CCD capture stage, fed by the camera GPIO pixel bus (DATA, FVAL, LVAL) in the CCD_PIXCLK domain.
- Adds start/stop arming on whole-frame boundaries, a runtime region-of-interest (ROI) window and frame decimation.
- Outputs a qualified pixel stream with X/Y position, a frame counter and a frame-done pulse to RAWToRGB and the SDRAM writer.

---
 rtl/ccd_capture_roi_pkg.sv | 25 ++
 rtl/ccd_sync_stage.sv | 57 +++++
 rtl/ccd_capture_roi.sv | 208 ++++++++++++++++++++
 tb/tb_ccd_capture_roi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_capture_roi_pkg.sv
// ============================================================================
// Module      : ccd_capture_roi_pkg
// Description : Shared state encodings and default widths for the ROI capture
//               stage and its input synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccd_capture_roi_pkg;

    localparam int c_DATA_W  = 12;
    localparam int c_CNT_W   = 16;
    localparam int c_FRAME_W = 32;
    localparam int c_SKIP_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURE  = 2'd2,
        STOPPING = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ccd_sync_stage.sv
// ============================================================================
// Module      : ccd_sync_stage
// Description : Registers the camera pixel bus and derives frame-start,
//               frame-end and line-end strobes from the registered valids.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccd_sync_stage #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_fval,
    input  logic              i_lval,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fval,
    output logic              o_lval,
    output logic              o_fs,
    output logic              o_fe,
    output logic              o_le
);

    logic [DATA_W-1:0] r_data;
    logic              r_fval;
    logic              r_fval_p;
    logic              r_lval;
    logic              r_lval_p;

    // FVAL history resets high so releasing reset inside a frame is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_fval   <= 1'b1;
            r_fval_p <= 1'b1;
            r_lval   <= 1'b0;
            r_lval_p <= 1'b0;
        end else begin
            r_data   <= i_data;
            r_fval   <= i_fval;
            r_fval_p <= r_fval;
            r_lval   <= i_lval;
            r_lval_p <= r_lval;
        end
    end

    assign o_data = r_data;
    assign o_fval = r_fval;
    assign o_lval = r_lval;
    assign o_fs   = r_fval & ~r_fval_p;
    assign o_fe   = ~r_fval & r_fval_p;
    assign o_le   = ~r_lval & r_lval_p;

endmodule

`default_nettype wire

// File: rtl/ccd_capture_roi.sv
// ============================================================================
// Module      : ccd_capture_roi
// Description : CCD capture with frame-aligned start/stop, runtime ROI window
//               and frame decimation; emits a qualified pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccd_capture_roi
    import ccd_capture_roi_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int CNT_W   = c_CNT_W,
    parameter int FRAME_W = c_FRAME_W,
    parameter int SKIP_W  = c_SKIP_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iSTOP,
    input  logic [CNT_W-1:0]   iROI_X0,
    input  logic [CNT_W-1:0]   iROI_X1,
    input  logic [CNT_W-1:0]   iROI_Y0,
    input  logic [CNT_W-1:0]   iROI_Y1,
    input  logic [SKIP_W-1:0]  iSKIP,
    output logic [DATA_W-1:0]  oDATA,
    output logic               oDVAL,
    output logic [CNT_W-1:0]   oX_Counter,
    output logic [CNT_W-1:0]   oY_Counter,
    output logic [FRAME_W-1:0] oFrame_Counter,
    output logic               oFrame_Done,
    output logic               oBusy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [DATA_W-1:0]  w_data;
    logic               w_fval;
    logic               w_lval;
    logic               w_fs;
    logic               w_fe;
    logic               w_le;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_y;
    logic [CNT_W-1:0]   r_x0;
    logic [CNT_W-1:0]   r_x1;
    logic [CNT_W-1:0]   r_y0;
    logic [CNT_W-1:0]   r_y1;
    logic [SKIP_W-1:0]  r_skip_sh;
    logic [SKIP_W-1:0]  r_skip_cnt;
    logic               r_selected;

    logic [DATA_W-1:0]  r_odata;
    logic               r_dval;
    logic [CNT_W-1:0]   r_ox;
    logic [CNT_W-1:0]   r_oy;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_done;

    logic               w_capt;
    logic               w_active;
    logic               w_sel;
    logic [CNT_W-1:0]   w_y;
    logic [CNT_W-1:0]   w_x0;
    logic [CNT_W-1:0]   w_x1;
    logic [CNT_W-1:0]   w_y0;
    logic [CNT_W-1:0]   w_y1;
    logic               w_dval_next;
    logic               w_frame_end;

    ccd_sync_stage #(
        .DATA_W (DATA_W)
    ) u_sync (
        .clk    (iCLK),
        .rst    (iRST),
        .i_data (iDATA),
        .i_fval (iFVAL),
        .i_lval (iLVAL),
        .o_data (w_data),
        .o_fval (w_fval),
        .o_lval (w_lval),
        .o_fs   (w_fs),
        .o_fe   (w_fe),
        .o_le   (w_le)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:     if (iSTART && !iSTOP) w_state_next = ARMED;
            ARMED:    if (iSTOP) w_state_next = IDLE;
                      else if (w_fs) w_state_next = CAPTURE;
            CAPTURE:  if (iSTOP) w_state_next = STOPPING;
            STOPPING: if (w_fe) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // On the frame-start cycle itself, use the values about to be latched so a
    // pixel coinciding with FVAL rising is qualified against the new frame.
    assign w_capt      = (r_state == CAPTURE) || (r_state == STOPPING);
    assign w_active    = w_capt || ((r_state == ARMED) && w_fs && !iSTOP);
    assign w_sel       = w_fs ? (r_skip_cnt == '0) : r_selected;
    assign w_y         = w_fs ? '0 : r_y;
    assign w_x0        = w_fs ? iROI_X0 : r_x0;
    assign w_x1        = w_fs ? iROI_X1 : r_x1;
    assign w_y0        = w_fs ? iROI_Y0 : r_y0;
    assign w_y1        = w_fs ? iROI_Y1 : r_y1;
    assign w_frame_end = w_fe && r_selected && w_capt;

    assign w_dval_next = w_active && w_sel && w_fval && w_lval &&
                         (r_x >= w_x0) && (r_x <= w_x1) &&
                         (w_y >= w_y0) && (w_y <= w_y1);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_le) begin
                r_x <= '0;
            end else if (w_fval && w_lval && (r_x != c_CNT_MAX)) begin
                r_x <= r_x + CNT_W'(1);
            end
            if (w_fs) begin
                r_y <= '0;
            end else if (w_le && w_fval && (r_y != c_CNT_MAX)) begin
                r_y <= r_y + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_x0       <= '0;
            r_x1       <= '0;
            r_y0       <= '0;
            r_y1       <= '0;
            r_skip_sh  <= '0;
            r_skip_cnt <= '0;
            r_selected <= 1'b0;
        end else begin
            if (w_fs) begin
                r_x0      <= iROI_X0;
                r_x1      <= iROI_X1;
                r_y0      <= iROI_Y0;
                r_y1      <= iROI_Y1;
                r_skip_sh <= iSKIP;
            end
            if (r_state == IDLE) begin
                r_skip_cnt <= '0;
                r_selected <= 1'b0;
            end else if (w_fs) begin
                r_selected <= (r_skip_cnt == '0);
                if (r_skip_cnt != '0) r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
            end else if (w_frame_end) begin
                // Reload the discard budget only after a frame that was kept.
                r_skip_cnt <= r_skip_sh;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_odata     <= '0;
            r_dval      <= 1'b0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_dval <= w_dval_next;
            if (w_dval_next) begin
                r_odata <= w_data;
                r_ox    <= r_x;
                r_oy    <= w_y;
            end
            r_done <= w_frame_end;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign oDATA          = r_odata;
    assign oDVAL          = r_dval;
    assign oX_Counter     = r_ox;
    assign oY_Counter     = r_oy;
    assign oFrame_Counter = r_frame_cnt;
    assign oFrame_Done    = r_done;
    assign oBusy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ccd_capture_roi.sv
// ============================================================================
// Module      : tb_ccd_capture_roi
// Description : Self-checking bench: table of ROI/decimation cases plus
//               hand-written start/stop/reset sequences, pixel scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ccd_capture_roi;

    localparam int DW = 12;
    localparam int CW = 16;
    localparam int FW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic          fval, lval, start, stop;
    logic [CW-1:0] roi_x0, roi_x1, roi_y0, roi_y1;
    logic [SW-1:0] skip;
    logic [DW-1:0] o_data;
    logic          o_dval;
    logic [CW-1:0] o_x, o_y;
    logic [FW-1:0] o_frame;
    logic          o_done, o_busy;

    always #5 clk = ~clk;

    ccd_capture_roi #(
        .DATA_W (DW), .CNT_W (CW), .FRAME_W (FW), .SKIP_W (SW)
    ) u_dut (
        .iCLK           (clk),
        .iRST           (rst),
        .iDATA          (data),
        .iFVAL          (fval),
        .iLVAL          (lval),
        .iSTART         (start),
        .iSTOP          (stop),
        .iROI_X0        (roi_x0),
        .iROI_X1        (roi_x1),
        .iROI_Y0        (roi_y0),
        .iROI_Y1        (roi_y1),
        .iSKIP          (skip),
        .oDATA          (o_data),
        .oDVAL          (o_dval),
        .oX_Counter     (o_x),
        .oY_Counter     (o_y),
        .oFrame_Counter (o_frame),
        .oFrame_Done    (o_done),
        .oBusy          (o_busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        int            cyc;
    } exp_t;

    typedef struct {
        int w, h, x0, x1, y0, y1, skp, nfr, exp_px, exp_fr;
    } case_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   dval_cnt = 0;
    int   fr_id = 0;
    int   m_x0, m_x1, m_y0, m_y1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every qualified output must match the oldest expected pixel
    // and arrive exactly two clocks after that pixel was presented.
    always @(negedge clk) begin : mon
        exp_t e;
        if (o_done) done_cnt++;
        if (o_dval) begin
            dval_cnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dval: got x=%0d y=%0d data=%h, expected no pixel",
                         o_x, o_y, o_data);
            end else begin
                e = q.pop_front();
                if (o_data !== e.d || o_x !== e.x || o_y !== e.y || (cyc - e.cyc) != 2) begin
                    bad++;
                    $display("FAIL pixel: got x=%0d y=%0d data=%h lat=%0d, expected x=%0d y=%0d data=%h lat=2",
                             o_x, o_y, o_data, cyc - e.cyc, e.x, e.y, e.d);
                end
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] pix(input int f, input int x, input int y);
        return {4'(f), 4'(y), 4'(x)};
    endfunction

    task automatic set_roi(input int a, input int b, input int c, input int d, input int s);
        roi_x0 = CW'(a); roi_x1 = CW'(b); roi_y0 = CW'(c); roi_y1 = CW'(d);
        skip   = SW'(s);
        m_x0 = a; m_x1 = b; m_y0 = c; m_y1 = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fval = 1'b0; lval = 1'b0; start = 1'b0; stop = 1'b0; data = '0;
        tick(2);
        rst = 1'b0;
        q.delete();
        done_cnt = 0;
        dval_cnt = 0;
        tick(2);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic drive_lines(input int w, input int h, input bit cap, input int fid);
        exp_t e;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                @(negedge clk);
                lval = 1'b1;
                data = pix(fid, xx, yy);
                if (cap && xx >= m_x0 && xx <= m_x1 && yy >= m_y0 && yy <= m_y1) begin
                    e.d = data; e.x = CW'(xx); e.y = CW'(yy); e.cyc = cyc;
                    q.push_back(e);
                end
            end
            @(negedge clk);
            lval = 1'b0;
            data = '0;
            tick(2);
        end
    endtask

    task automatic drive_frame(input int w, input int h, input bit cap);
        @(negedge clk); fval = 1'b1;
        tick(2);
        drive_lines(w, h, cap, fr_id);
        @(negedge clk); fval = 1'b0;
        tick(3);
        fr_id++;
    endtask

    task automatic check_reset_outputs();
        check("rst_dval",  o_dval, 0);
        check("rst_data",  o_data, 0);
        check("rst_x",     o_x, 0);
        check("rst_y",     o_y, 0);
        check("rst_frame", o_frame, 0);
        check("rst_done",  o_done, 0);
        check("rst_busy",  o_busy, 0);
    endtask

    case_t tbl[5];

    initial begin
        rst = 1'b1; fval = 1'b0; lval = 1'b0; start = 1'b0; stop = 1'b0; data = '0;
        set_roi(0, 7, 0, 3, 0);

        tbl[0] = '{w:8,  h:4, x0:0, x1:7, y0:0, y1:3, skp:0, nfr:2, exp_px:64, exp_fr:2};
        tbl[1] = '{w:16, h:8, x0:4, x1:7, y0:2, y1:3, skp:0, nfr:1, exp_px:8,  exp_fr:1};
        tbl[2] = '{w:4,  h:3, x0:0, x1:3, y0:0, y1:2, skp:2, nfr:6, exp_px:24, exp_fr:2};
        tbl[3] = '{w:6,  h:2, x0:5, x1:2, y0:0, y1:1, skp:0, nfr:1, exp_px:0,  exp_fr:1};
        tbl[4] = '{w:8,  h:4, x0:7, x1:7, y0:3, y1:3, skp:1, nfr:4, exp_px:2,  exp_fr:2};

        tick(2);
        check_reset_outputs();

        for (int c = 0; c < 5; c++) begin
            int nsel;
            do_reset();
            set_roi(tbl[c].x0, tbl[c].x1, tbl[c].y0, tbl[c].y1, tbl[c].skp);
            pulse_start();
            check($sformatf("c%0d_armed_busy", c), o_busy, 1);
            nsel = 0;
            for (int f = 0; f < tbl[c].nfr; f++) begin
                bit sel;
                sel = (f % (tbl[c].skp + 1)) == 0;
                drive_frame(tbl[c].w, tbl[c].h, sel);
                if (sel) nsel++;
                check($sformatf("c%0d_f%0d_frame_cnt", c, f), o_frame, nsel);
                check($sformatf("c%0d_f%0d_done_cnt", c, f), done_cnt, nsel);
            end
            tick(3);
            check($sformatf("c%0d_queue_left", c), q.size(), 0);
            check($sformatf("c%0d_pixels", c), dval_cnt, tbl[c].exp_px);
            check($sformatf("c%0d_frames", c), o_frame, tbl[c].exp_fr);
        end

        // iSTART arrives mid-frame: that frame is ignored, the next is captured.
        do_reset();
        set_roi(0, 7, 0, 3, 0);
        @(negedge clk); fval = 1'b1;
        tick(2);
        fork
            drive_lines(8, 4, 1'b0, fr_id);
            begin tick(10); start = 1'b1; tick(1); start = 1'b0; end
        join
        @(negedge clk); fval = 1'b0;
        tick(3);
        fr_id++;
        check("midstart_busy", o_busy, 1);
        check("midstart_frame_cnt", o_frame, 0);
        check("midstart_pixels0", dval_cnt, 0);
        drive_frame(8, 4, 1'b1);
        tick(2);
        check("midstart_pixels1", dval_cnt, 32);
        check("midstart_frame_cnt1", o_frame, 1);

        // iSTOP during frame 3: frame 3 completes in full, then idle.
        do_reset();
        pulse_start();
        drive_frame(8, 4, 1'b1);
        drive_frame(8, 4, 1'b1);
        @(negedge clk); fval = 1'b1;
        tick(2);
        fork
            drive_lines(8, 4, 1'b1, fr_id);
            begin tick(12); stop = 1'b1; tick(1); stop = 1'b0; end
        join
        @(negedge clk); fval = 1'b0;
        tick(3);
        fr_id++;
        check("stop_busy", o_busy, 0);
        check("stop_frame_cnt", o_frame, 3);
        check("stop_done_cnt", done_cnt, 3);
        drive_frame(8, 4, 1'b0);
        tick(2);
        check("stop_pixels", dval_cnt, 96);
        check("stop_frame_cnt_after", o_frame, 3);

        // Reset inside a captured frame, released while FVAL is still high.
        do_reset();
        pulse_start();
        @(negedge clk); fval = 1'b1;
        tick(3);
        check("rstmid_busy_before", o_busy, 1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs();
        rst = 1'b0;
        tick(1);
        pulse_start();
        drive_lines(8, 4, 1'b0, fr_id);
        @(negedge clk); fval = 1'b0;
        tick(3);
        fr_id++;
        check("rstmid_no_pixels", dval_cnt, 0);
        check("rstmid_frame_cnt0", o_frame, 0);
        drive_frame(8, 4, 1'b1);
        tick(2);
        check("rstmid_pixels", dval_cnt, 32);
        check("rstmid_frame_cnt1", o_frame, 1);

        // iSTART with iSTOP in the same cycle: stop wins, stays idle.
        do_reset();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("startstop_busy", o_busy, 0);
        drive_frame(8, 4, 1'b0);
        tick(2);
        check("startstop_pixels", dval_cnt, 0);
        check("startstop_frame_cnt", o_frame, 0);
        check("startstop_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
